// File: rtl/ifu_fetch_queue.sv
// Sequential instruction fetch: single-outstanding memory request, PC register and a
// DEPTH-entry instruction queue to decode. Define IFU_PERF_EN to add the perf counter ports.
module ifu_fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     INST_W   = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_mem_req_valid,
    input  logic                io_mem_req_ready,
    output logic [XLEN-1:0]     io_mem_req_addr,
    input  logic                io_mem_resp_valid,
    input  logic [2*INST_W-1:0] io_mem_resp_data,
    input  logic                io_redirect_valid,
    input  logic [XLEN-1:0]     io_redirect_pc,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [INST_W-1:0]   io_out_inst,
`ifdef IFU_PERF_EN
    output logic [63:0]         io_perf_fetched,
    output logic [63:0]         io_perf_stall,
`endif
    output logic [XLEN-1:0]     io_out_pc
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc_reg;
    logic [PTR_W-1:0]  wptr, rptr;
    logic [PTR_W:0]    count;
    logic [XLEN-1:0]   q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];

    logic              req_fire, push, pop;
    logic [INST_W-1:0] inst_sel;

    assign inst_sel = pc_reg[2] ? io_mem_resp_data[2*INST_W-1:INST_W]
                                : io_mem_resp_data[INST_W-1:0];

    always_comb begin
        state_nxt        = state;
        io_mem_req_valid = 1'b0;
        io_mem_req_addr  = pc_reg;
        push             = 1'b0;
        io_out_valid     = (count != '0) && !io_redirect_valid;
        case (state)
            IDLE: begin
                io_mem_req_valid = !reset && (count < CNT_FULL) && !io_redirect_valid;
                if (io_mem_req_valid && io_mem_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (io_redirect_valid)
                    state_nxt = io_mem_resp_valid ? IDLE : DROP;
                else if (io_mem_resp_valid) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (io_mem_resp_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        req_fire = io_mem_req_valid && io_mem_req_ready;
        pop      = io_out_valid && io_out_ready;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= RESET_PC;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
        end else if (io_redirect_valid) begin
            pc_reg <= io_redirect_pc;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_pc[wptr]   <= pc_reg;
                q_inst[wptr] <= inst_sel;
                wptr         <= wptr + PTR_W'(1);
                pc_reg       <= pc_reg + XLEN'(4);
            end
            if (pop)
                rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign io_out_inst = q_inst[rptr];
    assign io_out_pc   = q_pc[rptr];

    // Requests are only issued with a free slot, so a push into a full queue is a design bug.
    always_ff @(posedge clock) begin
        if (!reset && push)
            assert (count != CNT_FULL);
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            io_perf_fetched <= '0;
            io_perf_stall   <= '0;
        end else begin
            if (push)
                io_perf_fetched <= io_perf_fetched + 64'd1;
            if (!io_out_valid)
                io_perf_stall <= io_perf_stall + 64'd1;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = req_fire;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: a latency-configurable memory model feeds the DUT,
// delivered responses push expected {pc, inst} entries that are compared on every pop.
module tb_ifu_fetch_queue;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetched, perf_stall;
`endif

    ifu_fetch_queue #(
        .XLEN(64), .INST_W(32), .DEPTH(4), .RESET_PC(RST_PC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_mem_req_valid(mem_req_valid),
        .io_mem_req_ready(mem_req_ready),
        .io_mem_req_addr(mem_req_addr),
        .io_mem_resp_valid(mem_resp_valid),
        .io_mem_resp_data(mem_resp_data),
        .io_redirect_valid(redirect_valid),
        .io_redirect_pc(redirect_pc),
        .io_out_valid(out_valid),
        .io_out_ready(out_ready),
        .io_out_inst(out_inst),
`ifdef IFU_PERF_EN
        .io_perf_fetched(perf_fetched),
        .io_perf_stall(perf_stall),
`endif
        .io_out_pc(out_pc)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fire_cnt = 0;
    int          pop_cnt  = 0;
    logic [63:0] last_fire_addr = '0;
    logic [63:0] exp_pc = RST_PC;
    logic [63:0] pend_addr = '0;
    bit          outstanding = 0;
    bit          dropping = 0;
    bit          mem_en = 1;
    int          mem_lat = 1;
    int          lat_cnt = 0;
    ent_t        sb[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] word_of(input logic [63:0] a);
        logic [63:0] base;
        base = {a[63:3], 3'b000};
        return {inst_of(base + 64'd4), inst_of(base)};
    endfunction

    // One clock: capture pre-edge handshakes, then update the model and drive the memory.
    task automatic cycle();
        bit          fire, pop, rdir, rsp, rst;
        logic [63:0] addr, hpc, rpc;
        logic [31:0] hinst;
        ent_t        e;
        fire  = mem_req_valid && mem_req_ready;
        addr  = mem_req_addr;
        pop   = out_valid && out_ready;
        hpc   = out_pc;
        hinst = out_inst;
        rdir  = redirect_valid;
        rpc   = redirect_pc;
        rsp   = mem_resp_valid;
        rst   = reset;
        @(posedge clock);
        #1;
        mem_resp_valid = 1'b0;
        if (rst) begin
            outstanding = 0;
            dropping    = 0;
            sb.delete();
            exp_pc      = RST_PC;
            return;
        end
        if (pop) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_empty: popped pc %h inst %h, required no pop", hpc, hinst);
            end else begin
                e = sb.pop_front();
                pop_cnt++;
                if (hpc !== e.pc || hinst !== e.inst) begin
                    n_fail++;
                    $display("FAIL pop_entry: got pc %h inst %h, required pc %h inst %h",
                             hpc, hinst, e.pc, e.inst);
                end
            end
        end
        if (fire) begin
            n_checks++;
            fire_cnt++;
            last_fire_addr = addr;
            if (addr !== exp_pc) begin
                n_fail++;
                $display("FAIL req_addr: got %h, required %h", addr, exp_pc);
            end
        end
        if (rdir) begin
            sb.delete();
            exp_pc = rpc;
            if (outstanding) begin
                if (rsp) begin
                    outstanding = 0;
                    dropping    = 0;
                end else begin
                    dropping = 1;
                end
            end
        end else if (rsp && outstanding) begin
            if (!dropping) begin
                e.pc   = pend_addr;
                e.inst = inst_of(pend_addr);
                sb.push_back(e);
                exp_pc = exp_pc + 64'd4;
            end
            outstanding = 0;
            dropping    = 0;
        end
        if (fire) begin
            outstanding = 1;
            pend_addr   = addr;
            lat_cnt     = mem_lat;
        end
        if (outstanding && mem_en) begin
            if (lat_cnt <= 1) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = word_of(pend_addr);
            end else begin
                lat_cnt--;
            end
        end
    endtask

    task automatic wait_fire(input int max_cycles);
        int f0 = fire_cnt;
        int k  = 0;
        while (fire_cnt == f0 && k < max_cycles) begin
            cycle();
            k++;
        end
        n_checks++;
        if (fire_cnt == f0) begin
            n_fail++;
            $display("FAIL wait_fire: no request within %0d cycles, required one", max_cycles);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid: got %b, required 0", mem_req_valid);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_req: got valid %b addr %h, required 1 %h",
                     mem_req_valid, mem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int p0 = pop_cnt;
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        mem_lat       = 1;
        mem_en        = 1;
        repeat (20) cycle();
        n_checks++;
        if (pop_cnt - p0 < 8) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d pops in 20 cycles, required at least 8", pop_cnt - p0);
        end
    endtask

    task automatic test_full();
        int f0;
        out_ready = 1'b0;
        do_reset();
        f0 = fire_cnt;
        repeat (16) cycle();
        n_checks++;
        if (fire_cnt - f0 != 4 || sb.size() != 4) begin
            n_fail++;
            $display("FAIL full_fill: got %0d requests %0d entries, required 4 4", fire_cnt - f0, sb.size());
        end
        n_checks++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: got req_valid %b out_valid %b, required 0 1", mem_req_valid, out_valid);
        end
        out_ready = 1'b1;
        wait_fire(10);
        n_checks++;
        if (last_fire_addr !== RST_PC + 64'h10) begin
            n_fail++;
            $display("FAIL full_resume: got %h, required %h", last_fire_addr, RST_PC + 64'h10);
        end
        repeat (20) cycle();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        out_ready = 1'b0;
        while (sb.size() != 2 && k < 20) begin
            cycle();
            k++;
        end
        n_checks++;
        if (sb.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_fill: got %0d entries, required 2", sb.size());
        end
        for (int i = 0; i < 12; i++) begin
            out_ready = mem_resp_valid;
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() != 2) begin
                n_fail++;
                $display("FAIL b2b_count: iter %0d got out_valid %b entries %0d, required 1 2",
                         i, out_valid, sb.size());
            end
        end
        out_ready = 1'b1;
        repeat (10) cycle();
    endtask

    task automatic test_redirect_drop();
        out_ready = 1'b1;
        mem_lat   = 4;
        wait_fire(10);
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_redirect_cycle: got out_valid %b req_valid %b, required 0 0",
                     out_valid, mem_req_valid);
        end
        cycle();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_wait: got out_valid %b req_valid %b, required 0 0", out_valid, mem_req_valid);
        end
        mem_lat = 1;
        wait_fire(10);
        n_checks++;
        if (last_fire_addr !== 64'h8000_1000) begin
            n_fail++;
            $display("FAIL drop_resume: got %h, required %h", last_fire_addr, 64'h8000_1000);
        end
        repeat (12) cycle();
    endtask

    task automatic test_redirect_resp();
        mem_lat = 2;
        wait_fire(10);
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_redirect_out_valid: got %b, required 0", out_valid);
        end
        cycle();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_redirect_no_push: got out_valid %b, required 0", out_valid);
        end
        mem_lat = 1;
        wait_fire(10);
        n_checks++;
        if (last_fire_addr !== 64'h8000_2000) begin
            n_fail++;
            $display("FAIL resp_redirect_resume: got %h, required %h", last_fire_addr, 64'h8000_2000);
        end
        repeat (12) cycle();
    endtask

    task automatic test_reset_mid();
        int p0;
        mem_en = 0;
        wait_fire(10);
        cycle();
        reset = 1'b1;
        cycle();
        reset          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_mid_state: got out_valid %b req_valid %b addr %h, required 0 1 %h",
                     out_valid, mem_req_valid, mem_req_addr, RST_PC);
        end
        mem_en        = 1;
        mem_req_ready = 1'b1;
        wait_fire(10);
        n_checks++;
        if (last_fire_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_mid_first_req: got %h, required %h", last_fire_addr, RST_PC);
        end
        p0 = pop_cnt;
        repeat (10) cycle();
        n_checks++;
        if (pop_cnt - p0 < 3) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got %0d pops, required at least 3", pop_cnt - p0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_back_to_back();
        test_redirect_drop();
        test_redirect_resp();
        test_reset_mid();
        repeat (4) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
